ip_codma_launcher: RTL and testbench

- CPU-side initiator for the CoDMA control interface. It drives start, stop, task_pointer and status_pointer, and monitors busy and irq. It is the master end of the port the CoDMA exposes as a slave.
- Host logic pushes (task_pointer, status_pointer) pairs into a small queue. The launcher issues them one at a time, waits for each task to complete, and reports completion.
- Sits between a host/sequencer and ip_codma_top. Replaces hand-driven start/stop stimulus.

---
 rtl/ip_codma_launch_pkg.sv | 26 ++
 rtl/ip_codma_launch_fifo.sv | 75 +++++++
 rtl/ip_codma_launcher.sv | 225 ++++++++++++++++++++++
 tb/tb_ip_codma_launcher.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_launch_pkg.sv
// Shared types and default parameters for the CoDMA launcher.
//   launch_state_t : launcher FSM states
//   launch_entry_t : one queued launch (task pointer + status pointer)
package ip_codma_launch_pkg;

  localparam int unsigned PTR_W            = 32;
  localparam int unsigned DEF_DEPTH        = 4;
  localparam int unsigned DEF_START_HOLD   = 4;
  localparam int unsigned DEF_STOP_HOLD    = 2;
  localparam int unsigned DEF_BUSY_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4,
    ABORT     = 3'd5
  } launch_state_t;

  typedef struct packed {
    logic [PTR_W-1:0] task_ptr;
    logic [PTR_W-1:0] status_ptr;
  } launch_entry_t;

endpackage

// File: rtl/ip_codma_launch_fifo.sv
// Synchronous FIFO of launch entries with flush.
//   clk, rst      : clock, async active-high reset
//   push, data_in : write request (ignored when full or flushing)
//   pop           : read request (ignored when empty or flushing)
//   flush         : empties the queue; wins over push and pop
//   head_c        : entry at the read index (combinational)
//   level, full   : registered occupancy and full flag
//   level_nxt_c   : occupancy after the current edge (combinational)
module ip_codma_launch_fifo
  import ip_codma_launch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  launch_entry_t          data_in,
  input  logic                   pop,
  input  logic                   flush,
  output launch_entry_t          head_c,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level_nxt_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = IDX_W + 1;

  launch_entry_t    mem [DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && (level != '0) && !flush;
  assign head_c  = mem[rd_idx];

  // Occupancy after this edge
  always_comb begin
    level_nxt_c = level;
    if (flush)
      level_nxt_c = '0;
    else if (do_push && !do_pop)
      level_nxt_c = level + LVL_W'(1);
    else if (do_pop && !do_push)
      level_nxt_c = level - LVL_W'(1);
  end

  // Indices wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx <= '0;
      wr_idx <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      level <= level_nxt_c;
      full  <= (level_nxt_c == LVL_W'(DEPTH));
      if (flush) begin
        rd_idx <= '0;
        wr_idx <= '0;
      end else begin
        if (do_push) wr_idx <= wr_idx + IDX_W'(1);
        if (do_pop)  rd_idx <= rd_idx + IDX_W'(1);
      end
    end
  end

  // Storage needs no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= data_in;
  end

endmodule

// File: rtl/ip_codma_launcher.sv
// CPU-side initiator for the CoDMA control port: queues (task, status)
// pointer pairs, launches them one at a time and reports completion.
//   clk_i, reset_i          : clock, async active-high reset
//   push_*                  : host queue interface (valid/ready)
//   abort_i                 : stop the in-flight task and flush the queue
//   start_o, stop_o         : CoDMA control strobes
//   task/status_pointer_o   : pointers of the task most recently popped
//   busy_i, irq_i           : CoDMA status (irq_i is informational only)
//   done_*                  : one-cycle completion report, err = timeout/abort
//   level_o, idle_o         : queue occupancy, idle-and-empty flag
// Optional: define CODMA_LAUNCH_STATS_EN for stat_ok_o / stat_err_o counters.
module ip_codma_launcher
  import ip_codma_launch_pkg::*;
#(
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned START_HOLD   = DEF_START_HOLD,
  parameter int unsigned STOP_HOLD    = DEF_STOP_HOLD,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [PTR_W-1:0]       push_task_ptr_i,
  input  logic [PTR_W-1:0]       push_status_ptr_i,
  input  logic                   abort_i,
  output logic                   start_o,
  output logic                   stop_o,
  output logic [PTR_W-1:0]       task_pointer_o,
  output logic [PTR_W-1:0]       status_pointer_o,
  input  logic                   busy_i,
  input  logic                   irq_i,
  output logic                   done_valid_o,
  output logic [PTR_W-1:0]       done_task_ptr_o,
  output logic                   done_err_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   idle_o
`ifdef CODMA_LAUNCH_STATS_EN
  ,
  output logic [15:0]            stat_ok_o,
  output logic [15:0]            stat_err_o
`endif
);

  localparam int unsigned HOLD_MAX = (START_HOLD > STOP_HOLD) ? START_HOLD : STOP_HOLD;
  localparam int unsigned HCNT_W   = $clog2(HOLD_MAX + 1);
  localparam int unsigned TCNT_W   = $clog2(BUSY_TIMEOUT + 1);

  launch_state_t         state_q, state_n;
  logic [HCNT_W-1:0]     hcnt_q, hcnt_n;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_n, tcnt_inc;
  logic                  seen_q, seen_n;
  logic                  start_n, stop_n, done_n, err_n;
  logic                  pop, flush, timed_out;
  launch_entry_t         push_entry, head;
  logic                  full;
  logic [$clog2(DEPTH):0] level_nxt;
  logic                  unused_irq;

  // irq_i is not a completion criterion; busy_i falling is
  assign unused_irq = irq_i;

  assign push_entry   = '{task_ptr: push_task_ptr_i, status_ptr: push_status_ptr_i};
  assign push_ready_o = !full;

  ip_codma_launch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk_i),
    .rst         (reset_i),
    .push        (push_valid_i),
    .data_in     (push_entry),
    .pop         (pop),
    .flush       (flush),
    .head_c      (head),
    .level       (level_o),
    .full        (full),
    .level_nxt_c (level_nxt)
  );

  // Timeout counter counts from the first start_o cycle and saturates
  assign tcnt_inc  = (tcnt_q == TCNT_W'(BUSY_TIMEOUT)) ? tcnt_q : tcnt_q + TCNT_W'(1);
  assign timed_out = (tcnt_q >= TCNT_W'(BUSY_TIMEOUT - 1));

  // Next state; start_n/stop_n/done_n are the strobe values for the next cycle
  always_comb begin
    state_n = state_q;
    hcnt_n  = hcnt_q;
    tcnt_n  = tcnt_q;
    seen_n  = seen_q;
    start_n = 1'b0;
    stop_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    pop     = 1'b0;
    flush   = abort_i;
    case (state_q)
      IDLE: begin
        if (!abort_i && (level_o != '0)) begin
          pop     = 1'b1;
          state_n = LAUNCH;
          hcnt_n  = HCNT_W'(1);
          tcnt_n  = '0;
          seen_n  = 1'b0;
          start_n = 1'b1;
        end
      end
      LAUNCH: begin
        if (abort_i) begin
          state_n = ABORT;
          hcnt_n  = HCNT_W'(1);
          stop_n  = 1'b1;
        end else begin
          tcnt_n = tcnt_inc;
          if (busy_i) seen_n = 1'b1;
          if (hcnt_q < HCNT_W'(START_HOLD)) begin
            hcnt_n  = hcnt_q + HCNT_W'(1);
            start_n = 1'b1;
          end else if (busy_i || seen_q) begin
            state_n = RUN;
          end else if (timed_out) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = WAIT_BUSY;
          end
        end
      end
      WAIT_BUSY: begin
        if (abort_i) begin
          state_n = ABORT;
          hcnt_n  = HCNT_W'(1);
          stop_n  = 1'b1;
        end else begin
          tcnt_n = tcnt_inc;
          if (busy_i) begin
            state_n = RUN;
          end else if (timed_out) begin
            state_n = DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_i) begin
          state_n = ABORT;
          hcnt_n  = HCNT_W'(1);
          stop_n  = 1'b1;
        end else if (!busy_i) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      ABORT: begin
        // Hold stop for STOP_HOLD cycles, then wait for the engine to drain
        if (hcnt_q < HCNT_W'(STOP_HOLD)) begin
          hcnt_n = hcnt_q + HCNT_W'(1);
          stop_n = 1'b1;
        end else if (!busy_i) begin
          state_n = DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      hcnt_q           <= '0;
      tcnt_q           <= '0;
      seen_q           <= 1'b0;
      start_o          <= 1'b0;
      stop_o           <= 1'b0;
      done_valid_o     <= 1'b0;
      done_err_o       <= 1'b0;
      done_task_ptr_o  <= '0;
      task_pointer_o   <= '0;
      status_pointer_o <= '0;
      idle_o           <= 1'b1;
    end else begin
      state_q      <= state_n;
      hcnt_q       <= hcnt_n;
      tcnt_q       <= tcnt_n;
      seen_q       <= seen_n;
      start_o      <= start_n;
      stop_o       <= stop_n;
      done_valid_o <= done_n;
      idle_o       <= (state_n == IDLE) && (level_nxt == '0);
      if (done_n) begin
        done_err_o      <= err_n;
        done_task_ptr_o <= task_pointer_o;
      end
      if (pop) begin
        task_pointer_o   <= head.task_ptr;
        status_pointer_o <= head.status_ptr;
      end
    end
  end

`ifdef CODMA_LAUNCH_STATS_EN
  // Saturating completion counters, updated alongside the done pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stat_ok_o  <= '0;
      stat_err_o <= '0;
    end else if (done_n) begin
      if (err_n) begin
        if (stat_err_o != 16'hFFFF) stat_err_o <= stat_err_o + 16'd1;
      end else begin
        if (stat_ok_o != 16'hFFFF) stat_ok_o <= stat_ok_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ip_codma_launcher.sv
// Randomized bench for ip_codma_launcher against a timestamp-based
// reference model; a small CoDMA responder drives busy_i.
module tb_ip_codma_launcher;

  localparam int DEPTH = 4;
  localparam int SH    = 4;
  localparam int STH   = 2;
  localparam int BT    = 16;
  localparam int NCYC  = 3000;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_task_ptr_i;
  logic [31:0] push_status_ptr_i;
  logic        abort_i;
  logic        start_o;
  logic        stop_o;
  logic [31:0] task_pointer_o;
  logic [31:0] status_pointer_o;
  logic        busy_i;
  logic        irq_i;
  logic        done_valid_o;
  logic [31:0] done_task_ptr_o;
  logic        done_err_o;
  logic [2:0]  level_o;
  logic        idle_o;
`ifdef CODMA_LAUNCH_STATS_EN
  logic [15:0] stat_ok_o;
  logic [15:0] stat_err_o;
`endif

  always #5 clk = ~clk;

  ip_codma_launcher #(
    .DEPTH(DEPTH), .START_HOLD(SH), .STOP_HOLD(STH), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .push_valid_i      (push_valid_i),
    .push_ready_o      (push_ready_o),
    .push_task_ptr_i   (push_task_ptr_i),
    .push_status_ptr_i (push_status_ptr_i),
    .abort_i           (abort_i),
    .start_o           (start_o),
    .stop_o            (stop_o),
    .task_pointer_o    (task_pointer_o),
    .status_pointer_o  (status_pointer_o),
    .busy_i            (busy_i),
    .irq_i             (irq_i),
    .done_valid_o      (done_valid_o),
    .done_task_ptr_o   (done_task_ptr_o),
    .done_err_o        (done_err_o),
    .level_o           (level_o),
    .idle_o            (idle_o)
`ifdef CODMA_LAUNCH_STATS_EN
    ,
    .stat_ok_o         (stat_ok_o),
    .stat_err_o        (stat_err_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: queue plus timestamps of the in-flight task
  typedef struct packed { logic [31:0] t; logic [31:0] s; } ref_ent_t;
  ref_ent_t    mq[$];
  logic [31:0] m_task, m_status, m_dptr;
  bit          m_derr, seen;
  int          t0, run_from, abort_t, done_t, m_ok, m_bad;

  task automatic model_reset();
    mq.delete();
    m_task = 0; m_status = 0; m_dptr = 0; m_derr = 0; seen = 0;
    t0 = -1; run_from = -1; abort_t = -1; done_t = -1; m_ok = 0; m_bad = 0;
  endtask

  function automatic bit in_job(int c);
    return (t0 >= 0) && (c >= t0) && ((done_t < 0) || (c <= done_t));
  endfunction

  function automatic bit exp_start(int c);
    return (t0 >= 0) && (c >= t0) && (c < t0 + SH) &&
           ((abort_t < 0) || (c < abort_t)) && ((done_t < 0) || (c < done_t));
  endfunction

  function automatic bit exp_stop(int c);
    return (abort_t >= 0) && (c >= abort_t) && (c < abort_t + STH) &&
           ((done_t < 0) || (c < done_t));
  endfunction

  task automatic sched_done(int c, bit err);
    done_t = c + 1; m_derr = err; m_dptr = m_task;
    if (err) m_bad++; else m_ok++;
  endtask

  // Advance the model across the edge ending cycle c, using cycle-c inputs
  task automatic step(int c);
    int lvl;
    bit idle_now, active;
    ref_ent_t e;
    lvl      = mq.size();
    idle_now = !in_job(c);
    active   = in_job(c) && (c != done_t);
    if (active) begin
      if (abort_t >= 0) begin
        if ((c >= abort_t + STH - 1) && !busy_i) sched_done(c, 1'b1);
      end else if (abort_i) begin
        abort_t = c + 1;
      end else if (c <= t0 + SH - 1) begin
        if (busy_i) seen = 1'b1;
        if (c == t0 + SH - 1) begin
          if (seen) run_from = c + 1;
          else if (c - t0 >= BT - 1) sched_done(c, 1'b1);
        end
      end else if (run_from < 0) begin
        if (busy_i) run_from = c + 1;
        else if (c - t0 >= BT - 1) sched_done(c, 1'b1);
      end else if (!busy_i) begin
        sched_done(c, 1'b0);
      end
    end
    if (abort_i) begin
      mq.delete();
    end else begin
      if (idle_now && lvl > 0) begin
        e = mq.pop_front();
        m_task = e.t; m_status = e.s;
        t0 = c + 1; seen = 0; run_from = -1; abort_t = -1; done_t = -1;
      end
      if (push_valid_i && lvl != DEPTH) mq.push_back('{t: push_task_ptr_i, s: push_status_ptr_i});
    end
  endtask

  task automatic check_outputs(int c);
    bit dv;
    dv = (c == done_t);
    check_val("start", 32'(start_o), 32'(exp_start(c)));
    check_val("stop", 32'(stop_o), 32'(exp_stop(c)));
    check_val("done_valid", 32'(done_valid_o), 32'(dv));
    if (dv) begin
      check_val("done_err", 32'(done_err_o), 32'(m_derr));
      check_val("done_ptr", done_task_ptr_o, m_dptr);
    end
    check_val("level", 32'(level_o), 32'(mq.size()));
    check_val("ready", 32'(push_ready_o), 32'(mq.size() != DEPTH));
    check_val("idle", 32'(idle_o), 32'(!in_job(c) && mq.size() == 0));
    check_val("task_ptr", task_pointer_o, m_task);
    check_val("status_ptr", status_pointer_o, m_status);
`ifdef CODMA_LAUNCH_STATS_EN
    check_val("stat_ok", 32'(stat_ok_o), 32'(m_ok));
    check_val("stat_err", 32'(stat_err_o), 32'(m_bad));
`endif
  endtask

  // CoDMA responder: 0 quiet, 1 counting down to busy, 2 busy
  int cd, cd_cnt, cd_len, jobs;
  bit did_rst;

  task automatic drive_codma(int c);
    bit resp;
    int dly, len;
    if (exp_start(c) && c == t0) begin
      jobs++;
      if (jobs == 1) begin resp = 1; dly = 2; len = 20; end
      else if (jobs == 2) begin resp = 0; dly = 0; len = 1; end
      else begin
        resp = ($urandom % 5) != 0;
        dly  = int'($urandom_range(0, 8));
        len  = int'($urandom_range(1, 25));
      end
      cd = resp ? 1 : 0; cd_cnt = dly; cd_len = len;
    end
    if (exp_stop(c) && c == abort_t) begin
      if (cd == 2) begin
        dly = int'($urandom_range(0, 5));
        if (dly < cd_cnt) cd_cnt = dly;
      end else cd = 0;
    end
    case (cd)
      1: if (cd_cnt == 0) begin busy_i = 1'b1; cd = 2; cd_cnt = cd_len; end else cd_cnt--;
      2: if (cd_cnt == 0) begin busy_i = 1'b0; cd = 0; end else cd_cnt--;
      default: busy_i = 1'b0;
    endcase
    irq_i = (cd == 2) && (($urandom % 4) == 0);
  endtask

  initial begin
    reset_i = 1'b1; push_valid_i = 1'b0; push_task_ptr_i = '0; push_status_ptr_i = '0;
    abort_i = 1'b0; busy_i = 1'b0; irq_i = 1'b0;
    cd = 0; cd_cnt = 0; cd_len = 0; jobs = 0; did_rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_outputs(cyc);
      if (!did_rst && cyc > 1500 && exp_start(cyc)) begin
        // Asynchronous reset while start_o is high
        did_rst = 1;
        #1 reset_i = 1'b1;
        push_valid_i = 1'b0; abort_i = 1'b0; busy_i = 1'b0; irq_i = 1'b0;
        #1;
        check_val("rst_start", 32'(start_o), 32'd0);
        check_val("rst_level", 32'(level_o), 32'd0);
        check_val("rst_idle", 32'(idle_o), 32'd1);
        check_val("rst_ready", 32'(push_ready_o), 32'd1);
`ifdef CODMA_LAUNCH_STATS_EN
        check_val("rst_stat", 32'({stat_ok_o, stat_err_o}), 32'd0);
`endif
        @(negedge clk);
        reset_i = 1'b0;
        model_reset();
        cd = 0;
        step(cyc);
        continue;
      end
      if (cyc < 100) begin
        push_valid_i      = (cyc == 2) || (cyc == 50);
        push_task_ptr_i   = (cyc == 2) ? 32'h80 : 32'h100;
        push_status_ptr_i = 32'h0;
        abort_i           = 1'b0;
      end else begin
        push_valid_i      = ($urandom % 100) < 35;
        push_task_ptr_i   = $urandom & 32'hFFFF_FFF0;
        push_status_ptr_i = $urandom & 32'hFFFF_FFF0;
        abort_i           = ($urandom % 60) == 0;
      end
      drive_codma(cyc);
      step(cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
